// File: rtl/alu_result_demux.sv
// Registered 1:8 result demux steered by {C1,C2,C3}; each channel is a one-entry valid/ready holding register.
// Latency 1 cycle; in_ready drops only while the addressed channel is full and its consumer is not draining.
module alu_result_demux #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               C1,
    input  logic               C2,
    input  logic               C3,
    output logic [7:0]         out_valid,
    input  logic [7:0]         out_ready,
    output logic [8*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]   xfer_count
);

    logic [2:0] sel;
    logic       accept;
    logic [7:0] load;
    logic [7:0] drain;

    assign sel      = {C1, C2, C3};
    assign in_ready = ~out_valid[sel] | out_ready[sel];
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;

    always_comb begin
        load      = '0;
        load[sel] = accept;
    end

    // A same-cycle drain and load leaves the channel full with the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
        end else begin
            out_valid <= load | (out_valid & ~drain);
        end
    end

    for (genvar k = 0; k < 8; k++) begin : g_chan
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_data[k*WIDTH +: WIDTH] <= '0;
            end else if (load[k]) begin
                out_data[k*WIDTH +: WIDTH] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (accept) begin
            xfer_count <= xfer_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_result_demux.sv
// Directed bench for alu_result_demux: sweep, drain+refill, back-pressure isolation, streaming, wrap, async reset.
module tb_alu_result_demux;
    localparam int WIDTH = 16;
    localparam int CNT_W = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data = '0;
    logic               C1 = 1'b0;
    logic               C2 = 1'b0;
    logic               C3 = 1'b0;
    logic [7:0]         out_valid;
    logic [7:0]         out_ready = '0;
    logic [8*WIDTH-1:0] out_data;
    logic [CNT_W-1:0]   xfer_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_result_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .C1         (C1),
        .C2         (C2),
        .C3         (C3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .xfer_count (xfer_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic present(input int k, input logic [WIDTH-1:0] d);
        in_valid     = 1'b1;
        {C1, C2, C3} = 3'(k);
        in_data      = d;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [WIDTH-1:0] slice(input int k);
        return out_data[k*WIDTH +: WIDTH];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1;
        chk("rst_valid", out_valid, 32'h0);
        chk("rst_data_zero", (out_data == '0), 1);
        chk("rst_cnt", xfer_count, 32'h0);
        chk("rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep every select with consumers stalled
        for (int k = 0; k < 8; k++) begin
            present(k, 16'h1000 + 16'(k));
            #1 chk($sformatf("sweep_rdy%0d", k), in_ready, 1);
            step;
        end
        in_valid = 1'b0;
        chk("sweep_valid", out_valid, 32'hFF);
        for (int k = 0; k < 8; k++)
            chk($sformatf("sweep_slice%0d", k), slice(k), 32'h1000 + 32'(k));
        chk("sweep_cnt", xfer_count, 32'd8);
        present(3, 16'hDEAD);
        #1 chk("ninth_rdy", in_ready, 0);
        step;
        chk("ninth_cnt", xfer_count, 32'd8);
        chk("ninth_slice3", slice(3), 32'h1003);
        in_valid = 1'b0;

        // Same-cycle drain and refill on ch5
        out_ready = 8'h20;
        present(5, 16'hAAAA);
        #1 chk("dr_rdy0", in_ready, 1);
        step;
        present(5, 16'h5555);
        #1 chk("dr_rdy1", in_ready, 1);
        chk("dr_consumer", slice(5), 32'hAAAA);
        chk("dr_cvalid", out_valid[5], 1);
        step;
        in_valid  = 1'b0;
        out_ready = 8'h00;
        chk("dr_slice5", slice(5), 32'h5555);
        chk("dr_valid", out_valid, 32'hFF);
        chk("dr_cnt", xfer_count, 32'd10);
        out_ready = 8'hFF;
        step;
        out_ready = 8'h00;
        chk("drain_all", out_valid, 32'h0);

        // Back-pressure isolation between ch2 and ch6
        present(2, 16'h2222);
        #1 chk("bp_rdy_a", in_ready, 1);
        step;
        present(6, 16'h6001);
        #1 chk("bp_rdy_b", in_ready, 1);
        step;
        chk("bp_valid_a", out_valid, 32'h44);
        present(2, 16'h2001);
        out_ready = 8'h40;
        #1 chk("bp_stall0", in_ready, 0);
        step;
        chk("bp_par_drain", out_valid, 32'h04);
        chk("bp_hold6", slice(6), 32'h6001);
        chk("bp_hold2", slice(2), 32'h2222);
        out_ready = 8'h00;
        for (int i = 1; i < 3; i++) begin
            #1 chk($sformatf("bp_stall%0d", i), in_ready, 0);
            step;
        end
        chk("bp_stall_cnt", xfer_count, 32'd12);
        out_ready = 8'h04;
        #1 chk("bp_release", in_ready, 1);
        chk("bp_cons_a", slice(2), 32'h2222);
        step;
        chk("bp_slice2_a", slice(2), 32'h2001);
        out_ready = 8'h00;
        present(6, 16'h6002);
        #1 chk("bp_rdy6", in_ready, 1);
        step;
        present(2, 16'h2002);
        out_ready = 8'h04;
        #1 chk("bp_rdy2", in_ready, 1);
        chk("bp_cons_b", slice(2), 32'h2001);
        step;
        in_valid  = 1'b0;
        out_ready = 8'h00;
        chk("bp_slice2_b", slice(2), 32'h2002);
        chk("bp_slice6_b", slice(6), 32'h6002);
        chk("bp_valid_b", out_valid, 32'h44);
        chk("bp_cnt", xfer_count, 32'd15);
        out_ready = 8'hFF;
        step;
        out_ready = 8'h00;

        // Asynchronous reset with ch0, ch4, ch7 full
        present(0, 16'h0A0A); step;
        present(4, 16'h4E4E); step;
        present(7, 16'h7F7F); step;
        in_valid = 1'b0;
        chk("ar_valid_pre", out_valid, 32'h91);
        chk("ar_cnt_pre", xfer_count, 32'd18);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 32'h0);
        chk("ar_data_zero", (out_data == '0), 1);
        chk("ar_cnt", xfer_count, 32'h0);
        chk("ar_ready", in_ready, 1);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Streaming on ch7
        out_ready = 8'h80;
        for (int i = 0; i < 100; i++) begin
            present(7, 16'h7000 + 16'(i));
            #1 chk($sformatf("st_rdy%0d", i), in_ready, 1);
            step;
            chk($sformatf("st_data%0d", i), slice(7), 32'h7000 + 32'(i));
            chk($sformatf("st_vld%0d", i), out_valid[7], 1);
        end
        in_valid = 1'b0;
        chk("st_cnt", xfer_count, 32'd100);

        // Counter wrap
        present(7, 16'hBEEF);
        repeat (65435) step;
        chk("wrap_max", xfer_count, 32'hFFFF);
        step;
        chk("wrap_zero", xfer_count, 32'h0);
        in_valid  = 1'b0;
        out_ready = 8'h00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
